// File: rtl/reg_file_param.sv
// Parametrised 2-read/1-write register file with a reset-time clear sequencer,
// optional hardwired zero entry and same-operation write-to-read bypass.
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_opcode,
  input  logic             we,
  input  logic [AW-1:0]    addr1,
  input  logic [AW-1:0]    addr2,
  input  logic [AW-1:0]    addr3,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             out_valid,
  output logic             ready
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]       r_state;
  logic [AW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic             r_out_valid;

  logic             w_accept;
  logic             w_wr_ok;
  logic             w_clr_we;
  logic             w_last;
  logic [WIDTH-1:0] w_rd1;
  logic [WIDTH-1:0] w_rd2;

  assign w_accept = rst_n && (r_state == S_READY) && valid_opcode;
  assign w_clr_we = rst_n && (r_state == S_CLEAR);
  assign w_last   = (int'(r_cnt) == DEPTH - 1);
  // Writes beyond the array or into the hardwired zero entry are dropped.
  assign w_wr_ok  = we && (int'(addr3) < DEPTH) && !((ZERO_REG != 0) && (addr3 == '0));

  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if ((ZERO_REG != 0) && (a == '0))
      v = '0;
    else if (int'(a) >= DEPTH)
      v = '0;
    else if (w_wr_ok && (a == addr3))
      v = in;
    else
      v = r_mem[a];
    return v;
  endfunction

  always_comb begin
    w_rd1 = rd(addr1);
    w_rd2 = rd(addr2);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_out1      <= '0;
      r_out2      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_out_valid <= 1'b0;
          if (w_last) begin
            r_state <= S_READY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_out_valid <= valid_opcode;
          if (valid_opcode) begin
            r_out1 <= w_rd1;
            r_out2 <= w_rd2;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we)
      r_mem[r_cnt] <= '0;
    else if (w_accept && w_wr_ok)
      r_mem[addr3] <= in;
  end

  assign out1      = r_out1;
  assign out2      = r_out2;
  assign out_valid = r_out_valid;
  assign ready     = (r_state == S_READY);

endmodule

// File: tb/tb_reg_file_param.sv
// Scoreboard bench for reg_file_param: three instances (default, ZERO_REG=0,
// DEPTH=20) share stimulus; a per-instance reference model predicts outputs.
module tb_reg_file_param;

  logic        clk;
  logic        rst_n;
  logic        valid_opcode;
  logic        we;
  logic [4:0]  addr1;
  logic [4:0]  addr2;
  logic [4:0]  addr3;
  logic [31:0] din;

  logic [31:0] o1  [3];
  logic [31:0] o2  [3];
  logic        ov  [3];
  logic        rdy [3];

  reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .valid_opcode(valid_opcode), .we(we),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .in(din),
    .out1(o1[0]), .out2(o2[0]), .out_valid(ov[0]), .ready(rdy[0]));

  reg_file_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .valid_opcode(valid_opcode), .we(we),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .in(din),
    .out1(o1[1]), .out2(o2[1]), .out_valid(ov[1]), .ready(rdy[1]));

  reg_file_param #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1)) dut_d20 (
    .clk(clk), .rst_n(rst_n), .valid_opcode(valid_opcode), .we(we),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .in(din),
    .out1(o1[2]), .out2(o2[2]), .out_valid(ov[2]), .ready(rdy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          inst;
    logic        v;
    logic [31:0] o1;
    logic [31:0] o2;
  } exp_t;

  exp_t        sb_q [$];
  int          n_checks   = 0;
  int          n_failures = 0;
  int          depth [3]  = '{32, 32, 20};
  int          zr    [3]  = '{1, 0, 1};
  logic [31:0] m     [3][32];
  logic [31:0] lo1   [3];
  logic [31:0] lo2   [3];
  int          n_ops      = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic dropped(input int i, input logic w, input logic [4:0] a3);
    return !w || (int'(a3) >= depth[i]) || (zr[i] != 0 && a3 == 5'd0);
  endfunction

  function automatic logic [31:0] mrd(input int i, input logic [4:0] a, input logic w,
                                      input logic [4:0] a3, input logic [31:0] d);
    if (zr[i] != 0 && a == 5'd0) return 32'h0;
    if (int'(a) >= depth[i]) return 32'h0;
    if (!dropped(i, w, a3) && a == a3) return d;
    return m[i][a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      lo1[i] = 32'h0;
      lo2[i] = 32'h0;
      for (int j = 0; j < 32; j++) m[i][j] = 32'h0;
    end
  endtask

  task automatic op(input logic v, input logic w, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [4:0] a3, input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    valid_opcode = v; we = w; addr1 = a1; addr2 = a2; addr3 = a3; din = d;
    for (int i = 0; i < 3; i++) begin
      if (v) begin
        lo1[i] = mrd(i, a1, w, a3, d);
        lo2[i] = mrd(i, a2, w, a3, d);
        if (!dropped(i, w, a3)) m[i][a3] = d;
      end
      e.inst = i; e.v = v; e.o1 = lo1[i]; e.o2 = lo2[i];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    n_ops++;
    for (int k = 0; k < 3; k++) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq($sformatf("op%0d_i%0d_ov", n_ops, e.inst), {31'b0, ov[e.inst]}, {31'b0, e.v});
        check_eq($sformatf("op%0d_i%0d_o1", n_ops, e.inst), o1[e.inst], e.o1);
        check_eq($sformatf("op%0d_i%0d_o2", n_ops, e.inst), o2[e.inst], e.o2);
      end
    end
  endtask

  // abort_at > 0 re-asserts reset for one cycle that many edges into the clear.
  task automatic do_reset(input int lowcyc, input int abort_at);
    int cnt;
    int ready_at [3];
    logic all_rdy;
    @(negedge clk);
    rst_n = 1'b0; valid_opcode = 1'b0; we = 1'b0;
    repeat (lowcyc) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_i%0d_rdy", i), {31'b0, rdy[i]}, 32'd0);
      check_eq($sformatf("rst_i%0d_ov", i), {31'b0, ov[i]}, 32'd0);
      check_eq($sformatf("rst_i%0d_o1", i), o1[i], 32'h0);
      check_eq($sformatf("rst_i%0d_o2", i), o2[i], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    if (abort_at > 0) begin
      repeat (abort_at) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
    // Operations presented during the clear must be ignored.
    valid_opcode = 1'b1; we = 1'b1; addr1 = 5'd3; addr2 = 5'd3; addr3 = 5'd3; din = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) ready_at[i] = -1;
    cnt = 0;
    all_rdy = 1'b0;
    while (!all_rdy && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 15) begin valid_opcode = 1'b0; we = 1'b0; end
      all_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (!rdy[i]) begin
          all_rdy = 1'b0;
          check_eq($sformatf("clr_i%0d_c%0d_ov", i, cnt), {31'b0, ov[i]}, 32'd0);
        end else if (ready_at[i] < 0) begin
          ready_at[i] = cnt;
        end
      end
    end
    valid_opcode = 1'b0; we = 1'b0;
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("ready_lat_i%0d", i), ready_at[i], depth[i]);
    model_clear();
  endtask

  initial begin
    rst_n = 1'b0; valid_opcode = 1'b0; we = 1'b0;
    addr1 = '0; addr2 = '0; addr3 = '0; din = '0;
    model_clear();

    do_reset(2, 0);
    for (int a = 0; a < 32; a++) op(1'b1, 1'b0, 5'(a), 5'(a), 5'd0, 32'h0);

    op(1'b1, 1'b1, 5'd1, 5'd2, 5'd5, 32'h12085D78);
    op(1'b1, 1'b0, 5'd5, 5'd6, 5'd0, 32'h0);
    op(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);

    op(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'hDEADBEEF);
    op(1'b1, 1'b0, 5'd7, 5'd7, 5'd0, 32'h0);

    op(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF);
    op(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    op(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0);

    op(1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 32'h0000AAAA);
    op(1'b1, 1'b0, 5'd3, 5'd3, 5'd0, 32'h0);

    op(1'b1, 1'b1, 5'd0, 5'd0, 5'd25, 32'h00000055);
    op(1'b1, 1'b0, 5'd25, 5'd19, 5'd0, 32'h0);

    for (int n = 0; n < 200; n++)
      op(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
         5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), $urandom);
    for (int a = 0; a < 32; a++) op(1'b1, 1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0);

    do_reset(1, 10);
    op(1'b1, 1'b0, 5'd3, 5'd7, 5'd0, 32'h0);
    op(1'b1, 1'b0, 5'd5, 5'd19, 5'd0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule
